// File: rtl/alu_seq_pkg.sv
// Shared types and defaults for the ALU command sequencer and its ALU.
package alu_seq_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int NREG_DEF  = 4;

    typedef enum logic [2:0] {
        OP_NEG     = 3'd0,
        OP_INC     = 3'd1,
        OP_ADD     = 3'd2,
        OP_ADD_SHR = 3'd3,
        OP_AND     = 3'd4,
        OP_OR      = 3'd5,
        OP_PACK    = 3'd6,
        OP_LOAD    = 3'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } seq_state_t;

endpackage

// File: rtl/alu_op_sequencer_alu.sv
// Combinational 16-bit ALU: seven operations selected by opcode 0..6, carry-out dropped.
module ALU_struct_1
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [2:0]       opcode,
    output logic [WIDTH-1:0] outW,
    output logic             zero,
    output logic             negative
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] shr_b;
    logic [WIDTH-1:0] cin_w;

    assign shr_b = $unsigned($signed(b) >>> 1);
    assign cin_w = {{(WIDTH-1){1'b0}}, cin};

    always_comb begin
        outW = '0;
        case (opcode)
            3'd0:    outW = ~a + ONE;
            3'd1:    outW = a + ONE;
            3'd2:    outW = a + b + cin_w;
            3'd3:    outW = a + shr_b;
            3'd4:    outW = a & b;
            3'd5:    outW = a | b;
            3'd6:    outW = {a[7:0], b[7:0]};
            default: outW = '0;
        endcase
    end

    assign zero     = (outW == '0);
    assign negative = outW[WIDTH-1];

endmodule

// File: rtl/alu_op_sequencer.sv
// Accepts one register-to-register command, runs it through the ALU, writes back,
// and offers the result on a second handshake.
//   state   | meaning
//   IDLE    | cmd_ready high, operands latched on accept
//   EXEC    | ALU evaluates latched operands; result and rf[dst] written at exit
//   WB      | res_valid high, result held until res_ready
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NREG  = NREG_DEF,
    localparam int IDXW = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [IDXW-1:0]  cmd_dst,
    input  logic [IDXW-1:0]  cmd_srca,
    input  logic [IDXW-1:0]  cmd_srcb,
    input  logic             cmd_cin,
    input  logic [WIDTH-1:0] cmd_imm,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_zero,
    output logic             res_neg,
    output logic             busy
);

    seq_state_t       state_q, state_d;
    alu_op_t          op_q;
    logic [IDXW-1:0]  dst_q;
    logic             cin_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] rf [NREG];
    logic [WIDTH-1:0] res_data_q;
    logic             res_zero_q, res_neg_q;

    logic             accept;
    logic [2:0]       alu_opcode;
    logic [WIDTH-1:0] alu_out;
    logic             alu_zero, alu_neg;
    logic [WIDTH-1:0] result;
    logic             result_zero, result_neg;

    assign accept = cmd_valid && (state_q == ST_IDLE);

    // LOAD never reaches the ALU: it sees opcode 0 and its output is discarded.
    assign alu_opcode = (op_q == OP_LOAD) ? 3'd0 : op_q;

    ALU_struct_1 #(.WIDTH(WIDTH)) u_alu (
        .a        (a_q),
        .b        (b_q),
        .cin      (cin_q),
        .opcode   (alu_opcode),
        .outW     (alu_out),
        .zero     (alu_zero),
        .negative (alu_neg)
    );

    assign result      = (op_q == OP_LOAD) ? b_q : alu_out;
    assign result_zero = (op_q == OP_LOAD) ? (b_q == '0) : alu_zero;
    assign result_neg  = (op_q == OP_LOAD) ? b_q[WIDTH-1] : alu_neg;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cmd_valid) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_WB;
            ST_WB:   if (res_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_NEG;
            dst_q      <= '0;
            cin_q      <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            res_data_q <= '0;
            res_zero_q <= 1'b0;
            res_neg_q  <= 1'b0;
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q  <= alu_op_t'(cmd_op);
                dst_q <= cmd_dst;
                cin_q <= cmd_cin;
                a_q   <= rf[cmd_srca];
                b_q   <= (alu_op_t'(cmd_op) == OP_LOAD) ? cmd_imm : rf[cmd_srcb];
            end
            if (state_q == ST_EXEC) begin
                res_data_q <= result;
                res_zero_q <= result_zero;
                res_neg_q  <= result_neg;
                rf[dst_q]  <= result;
            end
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign res_valid = (state_q == ST_WB);
    assign res_data  = res_data_q;
    assign res_zero  = res_zero_q;
    assign res_neg   = res_neg_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with hand-computed expected results.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [1:0]  cmd_dst, cmd_srca, cmd_srcb;
    logic        cmd_cin;
    logic [15:0] cmd_imm;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        res_zero, res_neg;
    logic        busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_op_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_dst   (cmd_dst),
        .cmd_srca  (cmd_srca),
        .cmd_srcb  (cmd_srcb),
        .cmd_cin   (cmd_cin),
        .cmd_imm   (cmd_imm),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_zero  (res_zero),
        .res_neg   (res_neg),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic [2:0] op, input logic [1:0] dst, input logic [1:0] sa,
                           input logic [1:0] sb, input logic cin, input logic [15:0] imm);
        cmd_op   = op;
        cmd_dst  = dst;
        cmd_srca = sa;
        cmd_srcb = sb;
        cmd_cin  = cin;
        cmd_imm  = imm;
    endtask

    // Issue one command with res_ready high and check the WB-cycle result.
    task automatic run_cmd(input string tag, input logic [2:0] op, input logic [1:0] dst,
                           input logic [1:0] sa, input logic [1:0] sb, input logic cin,
                           input logic [15:0] imm, input logic [15:0] exp_data,
                           input logic exp_zero, input logic exp_neg);
        int wait_cnt;
        set_cmd(op, dst, sa, sb, cin, imm);
        res_ready = 1'b1;
        cmd_valid = 1'b1;
        wait_cnt  = 0;
        while (!cmd_ready && wait_cnt < 10) begin
            step();
            wait_cnt++;
        end
        if (wait_cnt >= 10) chk({tag, "_ready_timeout"}, 16'(cmd_ready), 16'd1);
        step();
        cmd_valid = 1'b0;
        chk({tag, "_exec_valid"}, 16'(res_valid), 16'd0);
        step();
        chk({tag, "_wb_valid"}, 16'(res_valid), 16'd1);
        chk({tag, "_data"}, res_data, exp_data);
        chk({tag, "_zero"}, 16'(res_zero), 16'(exp_zero));
        chk({tag, "_neg"}, 16'(res_neg), 16'(exp_neg));
        step();
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        set_cmd(3'd0, 2'd0, 2'd0, 2'd0, 1'b0, 16'h0000);
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_cmd_ready", 16'(cmd_ready), 16'd1);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_res_valid", 16'(res_valid), 16'd0);
        chk("rst_res_data", res_data, 16'h0000);
        chk("rst_res_zero", 16'(res_zero), 16'd0);
        chk("rst_res_neg", 16'(res_neg), 16'd0);

        run_cmd("add_r0", 3'd2, 2'd0, 2'd0, 2'd0, 1'b0, 16'h0, 16'h0000, 1'b1, 1'b0);

        // LOAD and add with carry
        run_cmd("load_r1", 3'd7, 2'd1, 2'd0, 2'd0, 1'b0, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0);
        run_cmd("load_r2", 3'd7, 2'd2, 2'd0, 2'd0, 1'b0, 16'h0001, 16'h0001, 1'b0, 1'b0);
        run_cmd("addc_r3", 3'd2, 2'd3, 2'd1, 2'd2, 1'b1, 16'h0, 16'h8001, 1'b0, 1'b1);
        run_cmd("rdbk_r3", 3'd5, 2'd3, 2'd3, 2'd3, 1'b0, 16'h0, 16'h8001, 1'b0, 1'b1);

        // Unary, shift, pack, logic (op 1 aliases src and dst)
        run_cmd("neg_r2", 3'd0, 2'd0, 2'd2, 2'd0, 1'b0, 16'h0, 16'hFFFF, 1'b0, 1'b1);
        run_cmd("inc_r0", 3'd1, 2'd0, 2'd0, 2'd0, 1'b0, 16'h0, 16'h0000, 1'b1, 1'b0);
        run_cmd("load_8000", 3'd7, 2'd1, 2'd0, 2'd0, 1'b0, 16'h8000, 16'h8000, 1'b0, 1'b1);
        run_cmd("addshr", 3'd3, 2'd2, 2'd0, 2'd1, 1'b0, 16'h0, 16'hC000, 1'b0, 1'b1);
        run_cmd("load_12ab", 3'd7, 2'd1, 2'd0, 2'd0, 1'b0, 16'h12AB, 16'h12AB, 1'b0, 1'b0);
        run_cmd("load_34cd", 3'd7, 2'd2, 2'd0, 2'd0, 1'b0, 16'h34CD, 16'h34CD, 1'b0, 1'b0);
        run_cmd("pack", 3'd6, 2'd3, 2'd1, 2'd2, 1'b0, 16'h0, 16'hABCD, 1'b0, 1'b1);
        run_cmd("and", 3'd4, 2'd3, 2'd1, 2'd2, 1'b0, 16'h0, 16'h1089, 1'b0, 1'b0);
        run_cmd("or", 3'd5, 2'd3, 2'd1, 2'd2, 1'b0, 16'h0, 16'h36EF, 1'b0, 1'b0);

        // Backpressure: LOAD r0, then a held OR r1=r0|r0 that must see the new r0
        res_ready = 1'b0;
        set_cmd(3'd7, 2'd0, 2'd0, 2'd0, 1'b0, 16'h5A5A);
        cmd_valid = 1'b1;
        step();
        set_cmd(3'd5, 2'd1, 2'd0, 2'd0, 1'b0, 16'h0);
        chk("bp_exec_ready", 16'(cmd_ready), 16'd0);
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_wb_valid", 16'(res_valid), 16'd1);
            chk("bp_wb_data", res_data, 16'h5A5A);
            chk("bp_wb_ready", 16'(cmd_ready), 16'd0);
            step();
        end
        chk("bp_still_wb", 16'(res_valid), 16'd1);
        res_ready = 1'b1;
        step();
        chk("bp_idle_ready", 16'(cmd_ready), 16'd1);
        chk("bp_idle_valid", 16'(res_valid), 16'd0);
        step();
        cmd_valid = 1'b0;
        chk("bp_second_exec", 16'(busy), 16'd1);
        step();
        chk("bp_second_valid", 16'(res_valid), 16'd1);
        chk("bp_second_data", res_data, 16'h5A5A);
        step();

        // Throughput: held valid, res_ready high -> accept every 3rd cycle
        set_cmd(3'd7, 2'd2, 2'd0, 2'd0, 1'b0, 16'h0042);
        cmd_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            chk("tp_ready", 16'(cmd_ready), 16'((i % 3) == 0));
            chk("tp_valid", 16'(res_valid), 16'((i % 3) == 2));
            if ((i % 3) == 2) chk("tp_data", res_data, 16'h0042);
            step();
        end
        cmd_valid = 1'b0;

        // Reset during EXEC
        set_cmd(3'd7, 2'd3, 2'd0, 2'd0, 1'b0, 16'h1111);
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        chk("mid_exec_busy", 16'(busy), 16'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_ready", 16'(cmd_ready), 16'd1);
        chk("mid_rst_valid", 16'(res_valid), 16'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mid_no_valid", 16'(res_valid), 16'd0);
        end
        run_cmd("clr_r0", 3'd5, 2'd0, 2'd0, 2'd0, 1'b0, 16'h0, 16'h0000, 1'b1, 1'b0);
        run_cmd("clr_r1", 3'd5, 2'd1, 2'd1, 2'd1, 1'b0, 16'h0, 16'h0000, 1'b1, 1'b0);
        run_cmd("clr_r2", 3'd5, 2'd2, 2'd2, 2'd2, 1'b0, 16'h0, 16'h0000, 1'b1, 1'b0);
        run_cmd("clr_r3", 3'd5, 2'd3, 2'd3, 2'd3, 1'b0, 16'h0, 16'h0000, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
